// File: rtl/aes_pkg.sv
// Shared AES controller constants: block width, round count, FSM encodings, round-key index type.
package aes_pkg;
    localparam int NR_128 = 10;
    localparam int BLK_W  = 128;

    typedef logic [1:0] fsm_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef logic [3:0] rk_idx_t;
endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer (state reg, round counter, handshakes), NR+1 cycles accept->out_valid, result held in DONE until out_ready.
// Optional AES_RC_PERF_CNT_EN adds blk_cnt, a wrapping count of completed output handshakes.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = NR_128,
    parameter int KEEP_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:BLK_W-1] din,
    output rk_idx_t          rk_idx,
    input  logic [0:BLK_W-1] rk,
    output logic [0:BLK_W-1] st_out,
    output logic             last_round,
    input  logic [0:BLK_W-1] round_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:BLK_W-1] dout,
`ifdef AES_RC_PERF_CNT_EN
    output logic [31:0]      blk_cnt,
`endif
    output logic             busy
);
    localparam int CW = $clog2(NR + 1);

    fsm_t             fsm_q, fsm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:BLK_W-1] st_q, st_d;
    logic [0:BLK_W-1] dout_q, dout_d;

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        dout_d = dout_q;
        case (fsm_q)
            IDLE: begin
                // rk_idx is 0 here, so rk is the whitening key.
                if (in_valid) begin
                    st_d  = din ^ rk;
                    cnt_d = CW'(1);
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_in;
                if (cnt_q == CW'(NR)) begin
                    dout_d = round_in;
                    fsm_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                    if (KEEP_OUT == 0) dout_d = '0;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            st_q   <= '0;
            dout_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            dout_q <= dout_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q == ROUND) || (fsm_q == DONE);
    assign rk_idx     = (fsm_q == ROUND) ? rk_idx_t'(cnt_q) : '0;
    assign last_round = (fsm_q == ROUND) && (cnt_q == CW'(NR));
    assign st_out     = st_q;
    assign dout       = dout_q;

`ifdef AES_RC_PERF_CNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            blk_cnt_q <= '0;
        else if (out_valid && out_ready)
            blk_cnt_q <= blk_cnt_q + 32'd1;
    end

    assign blk_cnt = blk_cnt_q;
`endif
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round datapath and key-schedule ROM around the controller,
// driven with FIPS-197 and SP800-38A vectors.
module tb_aes_round_ctrl;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] din;
    logic [3:0]   rk_idx;
    logic [0:127] rk;
    logic [0:127] st_out;
    logic         last_round;
    logic [0:127] round_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] dout;
    logic         busy;
`ifdef AES_RC_PERF_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    aes_round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .st_out     (st_out),
        .last_round (last_round),
        .round_in   (round_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
`ifdef AES_RC_PERF_CNT_EN
        .blk_cnt    (blk_cnt),
`endif
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                t[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = t[i] ^ k[8*i +: 8];
        return r;
    endfunction

    logic [0:127] rkeys [0:10];

    task automatic load_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    assign rk       = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;
    assign round_in = aes_round(st_out, rk, last_round);

    // ---------------- vectors ----------------
    localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PT_S1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [0:127] CT_S1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [0:127] PT_S2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [0:127] CT_S2  = 128'hf5d3d58503b9699de785895a96fdbaaf;

    // Offers one block at a negedge and returns at the first negedge with out_valid high.
    task automatic encrypt(input string tag, input logic [0:127] pt, input logic [0:127] ct,
                           input bit trace);
        int c0;
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        if (trace) chk({tag, "_rk_idle"}, 128'(rk_idx), 128'(0));
        din      = pt;
        in_valid = 1'b1;
        c0       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        din      = ~pt;
        k        = 1;
        while (!out_valid && k < 40) begin
            if (trace) begin
                chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(k));
                chk({tag, "_last_round"}, 128'(last_round), 128'(k == 10));
                chk({tag, "_busy"}, 128'(busy), 128'(1));
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 128'(cyc - c0), 128'(11));
        chk({tag, "_dout"}, dout, ct);
    endtask

    int           acc_cyc [2];
    int           nacc;
    int           nout;
    bit           acc_now;
    logic [0:127] exp_ct [2];
    int           k;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        load_key(KEY_B);
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   128'(in_ready),   128'(1));
        chk("rst_out_valid",  128'(out_valid),  128'(0));
        chk("rst_busy",       128'(busy),       128'(0));
        chk("rst_dout",       dout,             128'(0));
        chk("rst_rk_idx",     128'(rk_idx),     128'(0));
        chk("rst_last_round", 128'(last_round), 128'(0));
        chk("rst_st_out",     st_out,           128'(0));
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 Appendix B
        out_ready = 1'b1;
        encrypt("fips_b", PT_B, CT_B, 1'b0);
        @(negedge clk);
        chk("fips_b_idle", 128'(in_ready), 128'(1));

        // FIPS-197 C.1 with round tracing, then 20 cycles of backpressure
        load_key(KEY_C);
        out_ready = 1'b0;
        encrypt("fips_c1", PT_C, CT_C, 1'b1);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            din      = PT_B;
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_dout",      dout,            CT_C);
            chk("bp_in_ready",  128'(in_ready),  128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_in_ready",  128'(in_ready),  128'(1));
        chk("bp_rel_out_valid", 128'(out_valid), 128'(0));
        chk("bp_rel_busy",      128'(busy),      128'(0));
        chk("bp_rel_dout_kept", dout,            CT_C);

        // Third completed block
        load_key(KEY_B);
        encrypt("sp_1", PT_S1, CT_S1, 1'b0);
        @(negedge clk);
`ifdef AES_RC_PERF_CNT_EN
        chk("blk_cnt_3", 128'(blk_cnt), 128'(3));
`endif

        // Reset in round 5
        din      = PT_B;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (rk_idx != 4'd5 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_rk5", 128'(rk_idx), 128'(5));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_in_ready",  128'(in_ready),  128'(1));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_busy",      128'(busy),      128'(0));
        chk("mid_rk_idx",    128'(rk_idx),    128'(0));
        chk("mid_dout",      dout,            128'(0));
`ifdef AES_RC_PERF_CNT_EN
        chk("blk_cnt_rst", 128'(blk_cnt), 128'(0));
`endif
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_no_out", 128'(out_valid), 128'(0));
        encrypt("after_rst", PT_B, CT_B, 1'b0);
        @(negedge clk);

        // Back-to-back with in_valid held high
        exp_ct[0] = CT_S1;
        exp_ct[1] = CT_S2;
        nacc      = 0;
        nout      = 0;
        din       = PT_S1;
        in_valid  = 1'b1;
        for (int i = 0; i < 60 && nout < 2; i++) begin
            if (out_valid) begin
                chk("b2b_dout", dout, exp_ct[nout]);
                nout++;
            end
            acc_now = in_valid && in_ready;
            if (acc_now && nacc < 2) acc_cyc[nacc] = cyc;
            @(posedge clk);
            #1;
            if (acc_now) begin
                nacc++;
                if (nacc == 1) din = PT_S2;
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_n_out", 128'(nout), 128'(2));
        chk("b2b_n_acc", 128'(nacc), 128'(2));
        chk("b2b_gap",   128'(acc_cyc[1] - acc_cyc[0]), 128'(12));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption controller. It owns the 128-bit state register, the round counter and the valid/ready handshakes. It sequences the external combinational round datapath (SubBytes, ShiftRow, MixColumns, AddRoundKey) over 10 rounds, one round per clock. It sits between the SPI front-end (block in/out) and the round datapath/key-schedule ROM.

Parameters:
NR, 10, number of rounds (AES-128); counter width is $clog2(NR+1).
KEEP_OUT, 1, 1 = hold dout stable after handshake until next load; 0 = zero dout after handshake.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  plaintext block offered.
in_ready  out  1  controller can accept a block (IDLE only).
din  in  [0:127]  plaintext; byte 0 = bits 0:7, column-major.
rk_idx  out  4  round-key index requested from key schedule, 0..NR.
rk  in  [0:127]  round key for rk_idx, combinational, same cycle.
st_out  out  [0:127]  current state to round datapath.
last_round  out  1  datapath must bypass MixColumns this cycle.
round_in  in  [0:127]  datapath result: AddRoundKey(Mix?(ShiftRow(SubBytes(st_out))), rk).
out_valid  out  1  ciphertext valid.
out_ready  in  1  consumer accepts ciphertext.
dout  out  [0:127]  ciphertext.
busy  out  1  high in ROUND and DONE.

Behaviour:
- Reset (sync): state=IDLE, state reg=0, round cnt=0; in_ready=1, out_valid=0, busy=0, dout=0, rk_idx=0, last_round=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1, rk_idx=0. On in_valid&in_ready: state reg <= din ^ rk (initial AddRoundKey), cnt <= 1, go to ROUND.
- ROUND: rk_idx=cnt, st_out=state reg, last_round=(cnt==NR). Each cycle state reg <= round_in, cnt++. When cnt==NR: dout <= round_in, go to DONE.
- DONE: out_valid=1, busy=1, in_ready=0. On out_ready: out_valid drops next cycle, go to IDLE. Without out_ready: hold indefinitely, dout stable.
- Latency: accept at edge T; out_valid asserted after edge T+NR, i.e. 11 cycles from accept for NR=10. Peak throughput: one block per NR+2 cycles.
- in_valid outside IDLE: ignored, no state change, in_ready=0.
- out_ready outside DONE: ignored.
- KEEP_OUT=0: dout <= 0 on the DONE->IDLE transition.
- Reset mid-operation: aborts immediately. The block is lost and no out_valid is produced. All outputs take their reset values on the next edge.
- Counter never exceeds NR, and there is no wrap. Forcing an illegal FSM encoding returns the FSM to IDLE.
- st_out is driven with the state register in all states; it is only meaningful in ROUND.

Optional Feature:
AES_RC_PERF_CNT_EN. When defined, adds output blk_cnt [31:0]. The counter increments on each DONE handshake (out_valid&out_ready), wraps at 2^32-1 -> 0, and clears on reset. When not defined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg: NR_128=10, BLK_W=128, state enum (IDLE=2'd0, ROUND=2'd1, DONE=2'd2), rk index type.
- No sub-module required. The FSM and counter are one process; the datapath and key schedule remain external.
- Bench wraps the controller with the existing round datapath plus a key-schedule ROM.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> dout 3925841d02dc09fbdc118597196a0b32; out_valid exactly 11 cycles after accept.
- FIPS-197 C.1: key 000102...0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx sequence 0,1..10; last_round high only when rk_idx=10.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and dout stable, in_ready=0; in_valid pulses with a different din are ignored. Release -> IDLE the next cycle.
- Back-to-back: in_valid held high with two blocks, out_ready=1 -> second accept 12 cycles after the first; both ciphertexts correct.
- Reset asserted at round 5 -> next cycle IDLE, in_ready=1, out_valid=0, busy=0. A fresh block then encrypts correctly.
- With AES_RC_PERF_CNT_EN: 3 completed blocks -> blk_cnt=3; reset -> 0.
